// File: rtl/fetch_unit_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned DefBusWidth = 16;
  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefResetPc  = 0;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry prefetch buffer (valid/data/pc) between instruction memory and the IR.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DefBusWidth,
  parameter int unsigned ADDR_W    = DefAddrW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 load,
  input  logic [BUS_WIDTH-1:0] load_data,
  input  logic [ADDR_W-1:0]    load_pc,
  input  logic                 unload,
  output logic                 valid,
  output logic [BUS_WIDTH-1:0] data,
  output logic [ADDR_W-1:0]    pc
);

  logic                 valid_q;
  logic [BUS_WIDTH-1:0] data_q;
  logic [ADDR_W-1:0]    pc_q;

  // A load in the same cycle as an unload replaces the entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      pc_q    <= load_pc;
    end else if (unload) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request FSM and instruction register.
// Define FETCH_PREFETCH_BUF_EN to place a one-entry fetch_buf between memory and the IR.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DefBusWidth,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned RESET_PC  = DefResetPc
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ack,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  output logic [BUS_WIDTH-1:0] ir,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic [ADDR_W-1:0]    ir_pc,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  input  logic                 halt
);

  fetch_state_t         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d, redir_pc_q, redir_pc_d, ir_pc_q, ir_pc_d;
  logic                 req_q, req_d, redir_pend_q, redir_pend_d, ir_valid_q, ir_valid_d;
  logic [BUS_WIDTH-1:0] ir_q, ir_d;
  logic                 ack_ok, in_flight, consume, capture, full_next;

  assign ack_ok    = req_q & imem_ack;
  assign in_flight = req_q & ~imem_ack;
  assign consume   = ir_valid_q & ir_ready;
  // Data of a request overtaken by a redirect is dropped.
  assign capture   = ack_ok & ~redir_pend_q & ~redirect;

  // imem_addr is pc_q, so a redirect during an open request is parked until its ack.
  always_comb begin
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    if (redirect) begin
      if (in_flight) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = redirect_pc;
      end else begin
        pc_d         = redirect_pc;
        redir_pend_d = 1'b0;
      end
    end else if (ack_ok) begin
      pc_d         = redir_pend_q ? redir_pc_q : pc_q + ADDR_W'(1);
      redir_pend_d = 1'b0;
    end
  end

`ifdef FETCH_PREFETCH_BUF_EN
  logic                 buf_valid, buf_load, buf_unload, buf_valid_next;
  logic [BUS_WIDTH-1:0] buf_data;
  logic [ADDR_W-1:0]    buf_pc;

  fetch_buf #(
    .BUS_WIDTH(BUS_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_fetch_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .load     (buf_load),
    .load_data(imem_rdata),
    .load_pc  (pc_q),
    .unload   (buf_unload),
    .valid    (buf_valid),
    .data     (buf_data),
    .pc       (buf_pc)
  );

  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    if (redirect) begin
      ir_valid_d = 1'b0;
    end else if (!ir_valid_q || consume) begin
      if (buf_valid) begin
        ir_d       = buf_data;
        ir_pc_d    = buf_pc;
        ir_valid_d = 1'b1;
        buf_unload = 1'b1;
        buf_load   = capture;
      end else if (capture) begin
        ir_d       = imem_rdata;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
      end else begin
        ir_valid_d = 1'b0;
      end
    end else begin
      buf_load = capture;
    end
  end

  assign buf_valid_next = ~redirect & (buf_load | (buf_valid & ~buf_unload));
  assign full_next      = ir_valid_d & buf_valid_next;
`else
  // Requests start only with the IR empty, so an ack never meets a full IR.
  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (redirect) begin
      ir_valid_d = 1'b0;
    end else if (capture) begin
      ir_d       = imem_rdata;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end else if (consume) begin
      ir_valid_d = 1'b0;
    end
  end

  assign full_next = ir_valid_d;
`endif

  // A new request starts whenever none stays open, unless halted or storage is full.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    if (state_q == FETCH && in_flight) begin
      state_d = FETCH;
      req_d   = 1'b1;
    end else if (halt) begin
      state_d = HALTED;
      req_d   = 1'b0;
    end else if (full_next) begin
      state_d = WAIT_DRAIN;
      req_d   = 1'b0;
    end else begin
      state_d = FETCH;
      req_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= ADDR_W'(RESET_PC);
      req_q        <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BUS_WIDTH, default 16, instruction width, equal to the decode stage bus width.
REQ-002 Parameter ADDR_W, default 8, program counter and instruction-memory address width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low; sampled on rising clk edge.
REQ-006 imem_req  out  1  instruction-memory read request.
REQ-007 imem_addr  out  ADDR_W  read address, valid while imem_req is high.
REQ-008 imem_ack  in  1  memory completes request this cycle.
REQ-009 imem_rdata  in  BUS_WIDTH  instruction word, valid when imem_ack is high.
REQ-010 ir  out  BUS_WIDTH  instruction register presented to the decode stage.
REQ-011 ir_valid  out  1  ir holds a live instruction.
REQ-012 ir_ready  in  1  decode stage consumes ir this cycle when ir_valid is also high.
REQ-013 ir_pc  out  ADDR_W  address of the instruction currently in ir.
REQ-014 redirect  in  1  control-flow change request (jump/branch taken).
REQ-015 redirect_pc  in  ADDR_W  target address, valid with redirect.
REQ-016 halt  in  1  level request to stop issuing fetches.

Function
REQ-017 FSM states SHALL be FETCH, WAIT_DRAIN, HALTED.
REQ-018 FETCH: imem_req=1 and imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-019 On imem_ack in FETCH: ir<=imem_rdata, ir_pc<=pc, ir_valid<=1 and pc<=pc+1 on the same edge, giving 1-cycle latency from ack to ir_valid.
REQ-020 PC arithmetic SHALL be modulo 2^ADDR_W; the address after all-ones SHALL be 0.
REQ-021 After an ack with no prefetch storage free, state SHALL go to WAIT_DRAIN with imem_req=0.
REQ-022 WAIT_DRAIN: on ir_valid&&ir_ready, ir_valid<=0 and state SHALL return to FETCH.
REQ-023 A transfer SHALL occur only when ir_valid&&ir_ready; ir and ir_pc SHALL hold while ir_valid&&!ir_ready.
REQ-024 Redirect SHALL have top priority: ir_valid<=0, any buffered entry is flushed, and pc<=redirect_pc.
REQ-025 If redirect arrives while a request is outstanding (imem_req=1, no ack), the request SHALL run to ack and its data SHALL be discarded; the next request SHALL use redirect_pc.
REQ-026 If redirect coincides with imem_ack, the returned data SHALL be discarded and pc<=redirect_pc.
REQ-027 If halt is high when a new request would start, no request SHALL be issued and state SHALL go to HALTED; an outstanding request SHALL still complete and be captured normally.
REQ-028 HALTED: ir and ir_valid SHALL be retained and draining SHALL continue; redirect SHALL update pc; when halt is low, state SHALL return to FETCH, or to WAIT_DRAIN if storage is full.

Reset
REQ-029 While reset=0 at an edge: pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, imem_req=0, buffer empty, state=FETCH.
REQ-030 imem_req SHALL first rise in the cycle after reset is sampled high; reset mid-request SHALL abandon it and any later ack SHALL be ignored.

Configuration
REQ-031 Macro FETCH_PREFETCH_BUF_EN defined: a one-entry prefetch buffer (data and pc) sits between memory and ir, so fetching continues while ir is stalled.
REQ-032 With FETCH_PREFETCH_BUF_EN, when ir is consumed the buffer SHALL refill ir on the same edge, sustaining one instruction per cycle with a 1-cycle memory ack; WAIT_DRAIN is entered only when ir and the buffer are both full.
REQ-033 Macro undefined: no buffer; after every ack the FSM SHALL enter WAIT_DRAIN unless ir is consumed in the same cycle, giving at most one instruction per two cycles.

Structure
REQ-034 Shared package SHALL hold the FSM state typedef (fetch_state_t) and default constants for BUS_WIDTH, ADDR_W and RESET_PC.
REQ-035 The optional buffer SHALL be the sub-module fetch_buf (1-entry valid/data/pc register with flush); the PC and FSM stay in fetch_unit.

Verification
REQ-036 Reset released, RESET_PC=0, 1-cycle ack, ir_ready=1 -> imem_addr 0,1,2 in order; ir_pc follows 0,1,2; ir_valid rises 1 cycle after first ack.
REQ-037 ir_ready held 0 for 5 cycles with ir=0xA123 -> ir and ir_pc stable; imem_req=0 once storage is full; no instruction lost or duplicated.
REQ-038 pc=0xFF, ack -> next imem_addr=0x00.
REQ-039 redirect to 0x40 during an outstanding request at 0x05, ack 3 cycles later -> data from 0x05 discarded, ir_valid=0, next imem_addr=0x40.
REQ-040 halt=1 mid-stream -> the outstanding fetch completes, no further imem_req, ir drains; halt=0 -> fetching resumes from the next sequential pc.
REQ-041 reset=0 asserted during WAIT_DRAIN with ir_valid=1 -> all outputs at reset values on the next edge; run once with FETCH_PREFETCH_BUF_EN and once without.
